// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues sequential word fetches to instruction memory,
// queues in-order responses with their PCs, and presents the head to decode.
module instr_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  output logic            imem_req_valid_out,
  input  logic            imem_req_ready_in,
  output logic [XLEN-1:0] imem_req_addr_out,
  input  logic            imem_resp_valid_in,
  input  logic [31:0]     imem_resp_data_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  input  logic            stall_in,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid_out
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [31:0]      NOP       = 32'h0000_0013;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [XLEN-1:0]  fifo_pc    [DEPTH];
  logic [31:0]      fifo_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop;

  logic            req_fire;
  logic            resp_drop;
  logic            wr_en;
  logic            rd_en;
  logic [XLEN-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc_in & ~(XLEN'(3));

  // Entries already queued plus requests still in flight reserve FIFO space,
  // so a response always has a slot to land in.
  assign imem_req_valid_out = rst_n_in && !redirect_in &&
                              (({1'b0, count} + {1'b0, inflight}) < DEPTH_SUM);
  assign imem_req_addr_out  = fetch_pc;
  assign req_fire           = imem_req_valid_out && imem_req_ready_in;

  assign resp_drop = imem_resp_valid_in && (drop != '0);
  assign wr_en     = imem_resp_valid_in && (drop == '0) && !redirect_in;

  assign instr_valid_out = (count != '0);
  assign rd_en           = instr_valid_out && !stall_in && !redirect_in;
  assign instr_out       = instr_valid_out ? fifo_instr[rd_ptr] : NOP;
  assign pc_out          = instr_valid_out ? fifo_pc[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_resp_valid_in);
      if (redirect_in) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= redirect_pc_aligned;
        resp_pc  <= redirect_pc_aligned;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= inflight - CNT_W'(imem_resp_valid_in);
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + XLEN'(4);
        if (resp_drop) drop     <= drop - CNT_W'(1);
        if (wr_en) begin
          wr_ptr  <= wr_ptr + PTR_W'(1);
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
    end
  end

  // NOTE: the storage array has no reset; an entry is only read once count
  // says it was written, so its power-up contents never reach the outputs.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      fifo_instr[wr_ptr] <= imem_resp_data_in;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

  a_count_bound: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    count <= DEPTH_CNT);
  a_drop_bound: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    drop <= inflight);

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents the head instruction and its PC to decode.
- Supports decode stall and a pipeline redirect (branch/jump/trap), which flushes queued and in-flight fetches.

Parameters:
- RESET_PC, 64'h0, fetch address after reset; low two bits must be 0.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- XLEN, 64, PC/address width.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- imem_req_valid_out  output  1  fetch request valid.
- imem_req_ready_in  input  1  memory accepts request this cycle.
- imem_req_addr_out  output  XLEN  fetch address; word aligned.
- imem_resp_valid_in  input  1  response valid; in order, at least 1 cycle after acceptance.
- imem_resp_data_in  input  32  fetched instruction word.
- redirect_in  input  1  flush and restart fetch at redirect_pc_in.
- redirect_pc_in  input  XLEN  new fetch PC; bits [1:0] are forced to 0.
- stall_in  input  1  decode cannot consume the head this cycle.
- instr_out  output  32  head instruction, or 32'h00000013 (NOP) when empty.
- pc_out  output  XLEN  PC of the head instruction; 0 when empty.
- instr_valid_out  output  1  head entry is valid.

Behaviour:
- **State:**
  - fetch_pc (XLEN).
  - FIFO of {pc, instr} with rd_ptr/wr_ptr/count; count width is clog2(DEPTH)+1.
  - inflight counter (accepted, not yet responded).
  - drop counter (in-flight responses to discard).
- **Reset (async, rst_n_in low):**
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; drop=0.
  - imem_req_valid_out=0, imem_req_addr_out=RESET_PC.
  - instr_out=32'h00000013, pc_out=0, instr_valid_out=0.
  - Reset asserted mid-operation discards everything; later responses for pre-reset requests are not permitted by the memory contract.
- **Request issue:**
  - imem_req_valid_out = !redirect_in && (count + inflight < DEPTH).
  - imem_req_addr_out = fetch_pc.
  - Fire = valid && ready. On fire: fetch_pc += 4 (wraps modulo 2^XLEN); inflight += 1.
  - Valid may drop without ready only in a redirect cycle. Otherwise addr is held while valid and not ready.
- **Response:**
  - imem_resp_valid_in decrements inflight.
  - If drop>0: the response is discarded and drop decrements.
  - Otherwise the response is written to the FIFO at wr_ptr. Its pc is taken from a parallel in-order PC tag FIFO, or reconstructed as resp_pc register += 4 per accepted response.
  - Reservation guarantees the FIFO never overflows.
- **Consume:**
  - Head advances on instr_valid_out && !stall_in && !redirect_in.
  - instr_out/pc_out/instr_valid_out come combinationally from the head entry, so zero-cycle presentation once written.
  - Minimum latency from request fire to instr_valid_out is memory latency + 1 cycle (the FIFO write register).
- **Simultaneous write and consume:** count unchanged; pointers both advance. A write into an empty FIFO with stall_in low is consumed the following cycle.
- **Redirect (highest priority):**
  - In the redirect cycle: no request fires and no consume occurs.
  - Next state: FIFO emptied; fetch_pc=redirect_pc_in&~3; drop = inflight − resp_fire_this_cycle (includes prior drops); inflight updated normally.
  - Requests resume the cycle after redirect, subject to capacity.
  - Back-to-back redirects: the last one wins.
  - A redirect while stall_in is high still flushes.
- **Stall with full FIFO:** imem_req_valid_out=0 until an entry is consumed.
- **Word-count arithmetic:** count and inflight never exceed DEPTH. Assertions in simulation: count ≤ DEPTH, drop ≤ inflight.

Test Plan:
1. **Reset:** Release rst_n_in, RESET_PC=0x1000, ready=1, 1-cycle memory returning addr-derived words → requests 0x1000,0x1004,0x1008…; first instr_valid_out=1 two cycles after first fire, pc_out=0x1000; instr_out=0x00000013 and valid=0 before that.
2. **Stall fill:** stall_in=1 continuously, DEPTH=4 → exactly 4 requests fire, then imem_req_valid_out stays 0; release stall → entries 0x1000..0x100C consumed one per cycle in order, fetch resumes at 0x1010.
3. **Redirect with in-flight requests:** Use 3-cycle memory latency with 2 requests in flight; pulse redirect_in with redirect_pc_in=0x2002 → FIFO empties; the two stale responses are discarded; next request address is 0x2000; the first valid head has pc_out=0x2000.
4. **Backpressure:** imem_req_ready_in=0 for 5 cycles → imem_req_addr_out held constant, fetch_pc unchanged; one ready cycle → a single fire, address +4.
5. **Redirect coinciding with response:** redirect_in in the same cycle as imem_resp_valid_in, with inflight=1 → that response is dropped; drop=0 afterwards; no stale instruction appears.
6. **Wrap:** fetch_pc=0xFFFF_FFFF_FFFF_FFFC, one fire → next address 0x0, no X or overflow side effects.
